// File: rtl/forward_ctrl.sv
// forward_ctrl: EX-stage forwarding select generation, load-use detection and forwarding-event counters.
// Optional build macro FORWARD_CTRL_LOADUSE_STALL_EN adds stall_o and self-inserted load-use bubbles.
module forward_ctrl #(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memtoreg_i,
    output logic [1:0]        fwdA_o,
    output logic [1:0]        fwdB_o,
    output logic              loaduse_o,
    output logic [CNT_W-1:0]  fwd_exmem_cnt_o,
    output logic [CNT_W-1:0]  fwd_memwb_cnt_o
`ifdef FORWARD_CTRL_LOADUSE_STALL_EN
    ,
    output logic              stall_o
`endif
);

    localparam logic [1:0]        SEL_RF   = 2'b00;
    localparam logic [1:0]        SEL_MW   = 2'b01;
    localparam logic [1:0]        SEL_EM   = 2'b10;
    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    // Youngest non-load producer wins; a load in EX/MEM falls through to MEM/WB or the register file.
    function automatic logic [1:0] fwd_sel(
        input logic              em_rw,
        input logic              em_mtr,
        input logic [REG_AW-1:0] em_rd,
        input logic              mw_rw,
        input logic [REG_AW-1:0] mw_rd,
        input logic [REG_AW-1:0] src
    );
        logic em_hit;
        logic mw_hit;
        em_hit = em_rw & (em_rd != REG_ZERO) & (em_rd == src);
        mw_hit = mw_rw & (mw_rd != REG_ZERO) & (mw_rd == src);
        if (em_hit & ~em_mtr) begin
            fwd_sel = SEL_EM;
        end else if (mw_hit) begin
            fwd_sel = SEL_MW;
        end else begin
            fwd_sel = SEL_RF;
        end
    endfunction

    function automatic logic [1:0] sel_count(
        input logic [1:0] sel_a,
        input logic [1:0] sel_b,
        input logic [1:0] code
    );
        sel_count = {1'b0, (sel_a == code)} + {1'b0, (sel_b == code)};
    endfunction

    // The carry out of a CNT_W+1 bit sum signals overflow, which clamps to all-ones.
    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] cnt,
        input logic [1:0]       inc
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            sat_add = CNT_MAX;
        end else begin
            sat_add = sum[CNT_W-1:0];
        end
    endfunction

    logic              em_rw_r;
    logic              em_mtr_r;
    logic [REG_AW-1:0] em_rd_r;
    logic              mw_rw_r;
    logic [REG_AW-1:0] mw_rd_r;
    logic [CNT_W-1:0]  cnt_em_r;
    logic [CNT_W-1:0]  cnt_mw_r;

    logic              em_rw_nxt_s;
    logic              em_mtr_nxt_s;
    logic [REG_AW-1:0] em_rd_nxt_s;
    logic              mw_rw_nxt_s;
    logic [REG_AW-1:0] mw_rd_nxt_s;
    logic [CNT_W-1:0]  cnt_em_nxt_s;
    logic [CNT_W-1:0]  cnt_mw_nxt_s;

    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;
    logic              loaduse_s;
    logic              lu_bubble_s;

    // Operand selects and load-use flag from shadow state plus the instruction currently in EX.
    always_comb begin
        fwd_a_s   = fwd_sel(em_rw_r, em_mtr_r, em_rd_r, mw_rw_r, mw_rd_r, ex_rs_i);
        fwd_b_s   = fwd_sel(em_rw_r, em_mtr_r, em_rd_r, mw_rw_r, mw_rd_r, ex_rt_i);
        loaduse_s = ex_valid_i & em_rw_r & em_mtr_r & (em_rd_r != REG_ZERO) &
                    ((em_rd_r == ex_rs_i) | (em_rd_r == ex_rt_i));
    end

`ifdef FORWARD_CTRL_LOADUSE_STALL_EN
    assign lu_bubble_s = loaduse_s;
    assign stall_o     = loaduse_s;
`else
    assign lu_bubble_s = 1'b0;
`endif

    // Next shadow-pipeline and counter state; a stall freezes everything and swallows a flush.
    always_comb begin
        em_rw_nxt_s  = em_rw_r;
        em_mtr_nxt_s = em_mtr_r;
        em_rd_nxt_s  = em_rd_r;
        mw_rw_nxt_s  = mw_rw_r;
        mw_rd_nxt_s  = mw_rd_r;
        cnt_em_nxt_s = cnt_em_r;
        cnt_mw_nxt_s = cnt_mw_r;
        if (stall_i) begin
            em_rw_nxt_s = em_rw_r;
        end else begin
            mw_rw_nxt_s = em_rw_r;
            mw_rd_nxt_s = em_rd_r;
            if (flush_i | lu_bubble_s) begin
                em_rw_nxt_s  = 1'b0;
                em_mtr_nxt_s = 1'b0;
                em_rd_nxt_s  = REG_ZERO;
            end else begin
                em_rw_nxt_s  = ex_valid_i & ex_regwrite_i;
                em_mtr_nxt_s = ex_valid_i & ex_memtoreg_i;
                em_rd_nxt_s  = ex_rd_i;
            end
            if (ex_valid_i & ~lu_bubble_s) begin
                cnt_em_nxt_s = sat_add(cnt_em_r, sel_count(fwd_a_s, fwd_b_s, SEL_EM));
                cnt_mw_nxt_s = sat_add(cnt_mw_r, sel_count(fwd_a_s, fwd_b_s, SEL_MW));
            end else begin
                cnt_em_nxt_s = cnt_em_r;
                cnt_mw_nxt_s = cnt_mw_r;
            end
        end
    end

    // State registers with synchronous reset discarding all in-flight tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            em_rw_r  <= 1'b0;
            em_mtr_r <= 1'b0;
            em_rd_r  <= REG_ZERO;
            mw_rw_r  <= 1'b0;
            mw_rd_r  <= REG_ZERO;
            cnt_em_r <= CNT_ZERO;
            cnt_mw_r <= CNT_ZERO;
        end else begin
            em_rw_r  <= em_rw_nxt_s;
            em_mtr_r <= em_mtr_nxt_s;
            em_rd_r  <= em_rd_nxt_s;
            mw_rw_r  <= mw_rw_nxt_s;
            mw_rd_r  <= mw_rd_nxt_s;
            cnt_em_r <= cnt_em_nxt_s;
            cnt_mw_r <= cnt_mw_nxt_s;
        end
    end

    assign fwdA_o          = fwd_a_s;
    assign fwdB_o          = fwd_b_s;
    assign loaduse_o       = loaduse_s;
    assign fwd_exmem_cnt_o = cnt_em_r;
    assign fwd_memwb_cnt_o = cnt_mw_r;

endmodule

// File: tb/tb_forward_ctrl.sv
// Bench for forward_ctrl: directed vector table, saturation run and randomized reference-model checking.
module tb_forward_ctrl;

    localparam int CW   = 4;
    localparam int AW   = 5;
    localparam int CMAX = 15;
`ifdef FORWARD_CTRL_LOADUSE_STALL_EN
    localparam bit STALL_EN = 1'b1;
    localparam int LU_ADV   = 0;
`else
    localparam bit STALL_EN = 1'b0;
    localparam int LU_ADV   = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, stall, flush, valid, rw, mtr;
    logic [AW-1:0] rs, rt, rd;
    logic [1:0]    fwd_a, fwd_b;
    logic          lu;
    logic [CW-1:0] cnt_em, cnt_mw;
`ifdef FORWARD_CTRL_LOADUSE_STALL_EN
    logic          stall_out;
`endif

    forward_ctrl #(.CNT_W(CW), .REG_AW(AW)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .ex_valid_i(valid), .ex_rs_i(rs), .ex_rt_i(rt), .ex_rd_i(rd),
        .ex_regwrite_i(rw), .ex_memtoreg_i(mtr),
        .fwdA_o(fwd_a), .fwdB_o(fwd_b), .loaduse_o(lu),
        .fwd_exmem_cnt_o(cnt_em), .fwd_memwb_cnt_o(cnt_mw)
`ifdef FORWARD_CTRL_LOADUSE_STALL_EN
        , .stall_o(stall_out)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit st, fl, v;
        int rs, rt, rd;
        bit rw, mtr;
        int ea, eb;
        bit lu;
        int cem, cmw;
    } vec_t;

    function automatic vec_t mk(bit st, bit fl, bit v, int rs_v, int rt_v, int rd_v, bit rw_v, bit mtr_v,
                                int ea, int eb, bit lu_v, int cem, int cmw);
        vec_t r;
        r.st = st; r.fl = fl; r.v = v; r.rs = rs_v; r.rt = rt_v; r.rd = rd_v;
        r.rw = rw_v; r.mtr = mtr_v; r.ea = ea; r.eb = eb; r.lu = lu_v; r.cem = cem; r.cmw = cmw;
        return r;
    endfunction

    // Reference model: the two older instructions still able to supply a result, youngest first.
    bit m_w[2];
    bit m_ld[2];
    int m_rd[2];
    int m_cem, m_cmw;

    function automatic int m_sel(int src);
        if (src == 0) return 0;
        if (m_w[0] && m_rd[0] == src && !m_ld[0]) return 2;
        if (m_w[1] && m_rd[1] == src) return 1;
        return 0;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 2; i++) begin
            m_w[i] = 1'b0; m_ld[i] = 1'b0; m_rd[i] = 0;
        end
        m_cem = 0; m_cmw = 0;
    endtask

    task automatic drive(bit r, bit st, bit fl, bit v, int rs_v, int rt_v, int rd_v, bit rw_v, bit mtr_v);
        @(negedge clk);
        rst = r; stall = st; flush = fl; valid = v;
        rs = AW'(rs_v); rt = AW'(rt_v); rd = AW'(rd_v); rw = rw_v; mtr = mtr_v;
        #1;
    endtask

    task automatic check_comb(string tag, int ea, int eb, bit elu);
        check({tag, ".fwdA"}, int'(fwd_a), ea);
        check({tag, ".fwdB"}, int'(fwd_b), eb);
        check({tag, ".loaduse"}, int'(lu), int'(elu));
`ifdef FORWARD_CTRL_LOADUSE_STALL_EN
        check({tag, ".stall_o"}, int'(stall_out), int'(elu));
`endif
    endtask

    task automatic check_cnt(string tag, int cem, int cmw);
        @(posedge clk);
        #1;
        check({tag, ".cnt_exmem"}, int'(cnt_em), cem);
        check({tag, ".cnt_memwb"}, int'(cnt_mw), cmw);
    endtask

    vec_t tbl[$];

    initial begin
        int c2;
        int ea, eb, cnt_a, cnt_b;
        bit elu, bub;
        bit r, st, fl, v, rwv, mtrv;
        int rsv, rtv, rdv;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; valid = 1'b0;
        rs = '0; rt = '0; rd = '0; rw = 1'b0; mtr = 1'b0;
        repeat (2) @(posedge clk);

        // reset then idle
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
            check_comb("idle", 0, 0, 1'b0);
            check_cnt("idle", 0, 0);
        end

        c2 = 2 + LU_ADV;
        //                 st fl v  rs rt rd rw mtr  ea eb lu  cem cmw
        tbl.push_back(mk(0, 0, 1, 0, 0, 5, 1, 0,  0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 0, 1, 5, 5, 0, 0, 0,  2, 2, 0,  2, 0));
        tbl.push_back(mk(0, 0, 1, 5, 1, 0, 0, 0,  1, 0, 0,  2, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8, 1, 0,  0, 0, 0,  2, 1));
        tbl.push_back(mk(0, 0, 1, 8, 0, 8, 1, 0,  2, 0, 0,  3, 1));
        tbl.push_back(mk(0, 0, 1, 8, 8, 0, 0, 0,  2, 2, 0,  5, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0,  0, 0, 0,  5, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0,  5, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3, 1, 1,  0, 0, 0,  5, 1));
        tbl.push_back(mk(0, 0, 1, 1, 3, 0, 0, 0,  0, 0, 1,  5, 1));
        tbl.push_back(mk(0, 0, 1, 1, 3, 0, 0, 0,  0, 1, 0,  5, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3, 1, 0,  0, 0, 0,  5, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3, 1, 1,  0, 0, 0,  5, 2));
        tbl.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0,  1, 0, 1,  5, c2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 7, 1, 0,  0, 0, 0,  5, c2));
        tbl.push_back(mk(1, 0, 1, 7, 7, 0, 0, 0,  2, 2, 0,  5, c2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  5, c2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  5, c2));
        tbl.push_back(mk(0, 0, 1, 7, 0, 0, 0, 0,  2, 0, 0,  6, c2));
        tbl.push_back(mk(0, 1, 1, 0, 0, 9, 1, 0,  0, 0, 0,  6, c2));
        tbl.push_back(mk(0, 0, 1, 9, 9, 0, 0, 0,  0, 0, 0,  6, c2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0,  0, 0, 0,  6, c2));
        tbl.push_back(mk(0, 0, 1, 4, 0, 0, 0, 0,  0, 0, 0,  6, c2));

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(1'b0, tbl[i].st, tbl[i].fl, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].rw, tbl[i].mtr);
            check_comb(tag, tbl[i].ea, tbl[i].eb, tbl[i].lu);
            check_cnt(tag, tbl[i].cem, tbl[i].cmw);
        end

        // saturation: repeated writer to r10 that also reads r10 on both operands
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        check_cnt("sat_rst", 0, 0);
        for (int i = 0; i < 16; i++) begin
            string tag;
            tag = $sformatf("sat%0d", i);
            drive(1'b0, 1'b0, 1'b0, 1'b1, 10, 10, 10, 1'b1, 1'b0);
            check_comb(tag, (i == 0) ? 0 : 2, (i == 0) ? 0 : 2, 1'b0);
            check_cnt(tag, (2 * i > CMAX) ? CMAX : 2 * i, 0);
        end

        // randomized run against the reference model, with occasional mid-stream resets
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        check_cnt("rnd_rst", 0, 0);
        m_clear();
        for (int i = 0; i < 3000; i++) begin
            r    = ($urandom_range(0, 39) == 0);
            st   = ($urandom_range(0, 4) == 0);
            fl   = ($urandom_range(0, 7) == 0);
            v    = ($urandom_range(0, 3) != 0);
            rsv  = $urandom_range(0, 3);
            rtv  = $urandom_range(0, 3);
            rdv  = $urandom_range(0, 3);
            rwv  = ($urandom_range(0, 2) != 0);
            mtrv = ($urandom_range(0, 2) == 0);
            drive(r, st, fl, v, rsv, rtv, rdv, rwv, mtrv);

            ea  = m_sel(rsv);
            eb  = m_sel(rtv);
            elu = v && m_w[0] && m_ld[0] && m_rd[0] != 0 && (m_rd[0] == rsv || m_rd[0] == rtv);
            check_comb("rnd", ea, eb, elu);

            if (r) begin
                m_clear();
            end else if (!st) begin
                bub = fl || (STALL_EN && elu);
                if (v && !(STALL_EN && elu)) begin
                    cnt_a = (ea == 2 ? 1 : 0) + (eb == 2 ? 1 : 0);
                    cnt_b = (ea == 1 ? 1 : 0) + (eb == 1 ? 1 : 0);
                    m_cem = (m_cem + cnt_a > CMAX) ? CMAX : m_cem + cnt_a;
                    m_cmw = (m_cmw + cnt_b > CMAX) ? CMAX : m_cmw + cnt_b;
                end
                m_w[1]  = m_w[0];
                m_ld[1] = m_ld[0];
                m_rd[1] = m_rd[0];
                m_w[0]  = bub ? 1'b0 : (v && rwv);
                m_ld[0] = bub ? 1'b0 : (v && mtrv);
                m_rd[0] = bub ? 0 : rdv;
            end
            check_cnt("rnd", m_cem, m_cmw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/forward_ctrl.md
Name: forward_ctrl

Overview:
- Upstream neighbour of the EX-stage operand forwarding muxes. Produces their 2-bit select codes for operand A (rs) and operand B (rt).
- Tracks destination register, RegWrite and MemtoReg of the instructions in MEM and WB. It keeps its own shadow EX/MEM and MEM/WB registers, so no external pipeline-register taps are needed.
- Flags load-use hazards and keeps saturating forwarding-event counters for performance debug.

Parameters:
- CNT_W, 16: width of each forwarding-event counter.
- REG_AW, 5: register-address width. Register 0 is hard-wired zero.

Ports:
- clk_i  input  1  core clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- stall_i  input  1  freeze: hold every internal register and counter.
- flush_i  input  1  insert bubble into shadow EX/MEM on next edge.
- ex_valid_i  input  1  EX stage holds a real instruction.
- ex_rs_i  input  REG_AW  EX instruction source register A.
- ex_rt_i  input  REG_AW  EX instruction source register B.
- ex_rd_i  input  REG_AW  EX instruction destination (already rd/rt-muxed).
- ex_regwrite_i  input  1  EX instruction writes the register file.
- ex_memtoreg_i  input  1  EX instruction is a load.
- fwdA_o  output  2  operand A select.
- fwdB_o  output  2  operand B select.
- loaduse_o  output  1  load in MEM matches an EX source.
- fwd_exmem_cnt_o  output  CNT_W  count of EX/MEM forwards.
- fwd_memwb_cnt_o  output  CNT_W  count of MEM/WB forwards.

Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.

Behaviour:
- Select encoding: 2'b10 = EX/MEM ALU result; 2'b01 = MEM/WB write-back data; 2'b00 = register-file data. 2'b11 is never driven, including during and after reset.
- Shadow state: em_{rw,mtr,rd} and mw_{rw,rd}.
- Per edge, when stall_i=0:
  - em captures {ex_valid_i & ex_regwrite_i, ex_valid_i & ex_memtoreg_i, ex_rd_i}.
  - flush_i=1 loads em with {0,0,0} instead.
  - mw captures {em_rw, em_rd}.
- Per edge, when stall_i=1: all shadow state and counters hold. stall_i dominates flush_i; a flush during a stall is dropped, and the controller re-asserts it.
- Reset: all shadow state 0, both counters 0. Hence fwdA_o=fwdB_o=2'b00 and loaduse_o=0 in the first cycle after reset. Reset asserted mid-stream discards all in-flight tracking on that edge.
- Forward decision for operand X in {A:rs, B:rt}, combinational from shadow state plus current inputs:
  - em_hit = em_rw & (em_rd!=0) & (em_rd==src).
  - mw_hit = mw_rw & (mw_rd!=0) & (mw_rd==src).
  - If em_hit & !em_mtr: select 2'b10.
  - Else if mw_hit: select 2'b01. This covers the case em_hit & em_mtr, which falls through to MEM/WB or 00.
  - Else: select 2'b00.
  - Both em_hit and mw_hit (non-load): EX/MEM wins (youngest producer).
  - src==0 never forwards.
- loaduse_o = ex_valid_i & em_rw & em_mtr & (em_rd!=0) & ((em_rd==ex_rs_i) | (em_rd==ex_rt_i)). Combinational.
- Counters:
  - Advance only on edges with stall_i=0 and ex_valid_i=1.
  - fwd_exmem_cnt_o adds the number of operands selecting 2'b10 (0, 1 or 2); fwd_memwb_cnt_o likewise for 2'b01.
  - Both saturate at all-ones; an add that would overflow clamps to max.
- Latency: a producer entering EX at cycle N is forwardable as 2'b10 at cycle N+1 and as 2'b01 at cycle N+2 (stall cycles excluded).

Optional Feature:
- Macro: FORWARD_CTRL_LOADUSE_STALL_EN.
- Defined:
  - Adds output stall_o (1 bit) = loaduse_o.
  - On an edge where loaduse_o=1 and stall_i=0, em is loaded with a bubble (as flush), mw advances normally, and counters do not advance.
  - The held EX instruction is re-evaluated next cycle and obtains 2'b01 from MEM/WB.
- Undefined: no stall_o port. loaduse_o is informational only; shadow pipeline advances unchanged.

Test Plan:
- Reset then idle (ex_valid_i=0) -> fwdA_o=fwdB_o=00, loaduse_o=0, counters 0 for 10 cycles.
- Cycle N: rd=5, regwrite=1. Cycle N+1: rs=5, rt=5 -> fwdA_o=fwdB_o=10, fwd_exmem_cnt_o=2 after edge. Cycle N+2: consumer with rs=5 -> fwdA_o=01.
- Back-to-back writers to r8 (ALU), then consumer rs=8 -> fwdA_o=10 (youngest wins). Writer to r0 then rs=0 -> 00.
- Load to r3 then consumer rt=3 -> loaduse_o=1, fwdB_o=00. With FORWARD_CTRL_LOADUSE_STALL_EN: stall_o=1 one cycle, then fwdB_o=01.
- Writer r7 at N, stall_i=1 for 3 cycles with flush_i=1 on second -> consumer rs=7 after release gets 10; flush dropped. flush_i alone after writer -> consumer gets 00.
- Preload counters near max (CNT_W=4, 15 dual forwards) -> fwd_exmem_cnt_o saturates at 15, never wraps.
